// File: rtl/msx_slot_pkg.sv
// msx_slot_pkg
//   Shared types and constants for the MSX slot expander.
//   slot_t         : primary or secondary slot number (0..3)
//   sslot_reg_t    : one secondary-slot register (four 2-bit page fields)
//   SSLOT_ADDR_DEF : default memory address of the secondary-slot register
package msx_slot_pkg;

    typedef logic [1:0] slot_t;
    typedef logic [7:0] sslot_reg_t;

    localparam logic [15:0] SSLOT_ADDR_DEF = 16'hFFFF;

endpackage

// File: rtl/msx_slot_expander.sv
// msx_slot_expander
//   Resolves the primary slot from the PPI port-A image and adds MSX2-style
//   secondary-slot expansion. Every primary slot flagged in EXPANDED_MASK owns
//   an 8-bit subslot register at SSLOT_ADDR; reads of that address return the
//   inverted register contents.
//
// Ports
//   clk21m          in   system clock
//   reset_n         in   asynchronous active-low reset
//   cpu_addr        in   CPU address bus (page = cpu_addr[15:14])
//   cpu_dout        in   CPU write data
//   cpu_mreq        in   memory request, high for the whole bus cycle
//   cpu_rd / cpu_wr in   read / write qualifiers
//   ppi_out_a       in   primary slot register image, 2 bits per page
//   ppi_wr          in   one-cycle strobe: PPI has been written
//   map_valid       out  primary map programmed since reset
//   active_slot     out  primary slot of the current page
//   active_subslot  out  subslot of the current page (0 when not expanded)
//   sslot_hit       out  current cycle reads an expanded subslot register
//   sslot_dout      out  inverted subslot register of the page-3 slot
//   sslot_changed   out  one-cycle pulse after a subslot register update
//
// Bus handshake: a write is accepted on the first edge where the subslot
// register is hit with cpu_wr high. A lock then holds off further writes
// until cpu_mreq drops, so a write stretched over several clocks (or whose
// data or slot map changes meanwhile) updates the register exactly once.
module msx_slot_expander
    import msx_slot_pkg::*;
#(
    parameter logic [3:0]  EXPANDED_MASK = 4'b1000,
    parameter logic [15:0] SSLOT_ADDR    = SSLOT_ADDR_DEF,
    parameter sslot_reg_t  RESET_SSLOT   = 8'h00
) (
    input  logic        clk21m,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  ppi_out_a,
    input  logic        ppi_wr,
    output logic        map_valid,
    output slot_t       active_slot,
    output slot_t       active_subslot,
    output logic        sslot_hit,
    output sslot_reg_t  sslot_dout,
    output logic        sslot_changed
);

    sslot_reg_t sslot_q [4];
    logic       map_valid_q, map_valid_d;
    logic       lock_q, lock_d;
    logic       changed_q;

    logic [1:0] page;
    slot_t      cur_slot;
    slot_t      cur_sub;
    slot_t      p3slot;
    logic       p3_expanded;
    logic       hit;
    logic       wr_fire;

    always_comb begin
        page        = cpu_addr[15:14];
        cur_slot    = '0;
        cur_sub     = '0;
        if (map_valid_q) begin
            cur_slot = ppi_out_a[{page, 1'b0} +: 2];
        end
        if (EXPANDED_MASK[cur_slot]) begin
            cur_sub = sslot_q[cur_slot][{page, 1'b0} +: 2];
        end

        // The subslot register always belongs to the slot mapped into page 3,
        // since that is where SSLOT_ADDR lives.
        p3slot      = map_valid_q ? ppi_out_a[7:6] : 2'd0;
        p3_expanded = EXPANDED_MASK[p3slot];
        hit         = cpu_mreq && (cpu_addr == SSLOT_ADDR) && p3_expanded;
        wr_fire     = hit && cpu_wr && !lock_q;

        // Lock clears only when the bus cycle ends; a fresh write cannot
        // coincide with that because it needs cpu_mreq high.
        lock_d      = lock_q;
        if (!cpu_mreq) begin
            lock_d = 1'b0;
        end else if (wr_fire) begin
            lock_d = 1'b1;
        end

        map_valid_d = map_valid_q | ppi_wr;
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                sslot_q[i] <= RESET_SSLOT;
            end
            map_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            if (wr_fire) begin
                sslot_q[p3slot] <= cpu_dout;
            end
            map_valid_q <= map_valid_d;
            lock_q      <= lock_d;
            changed_q   <= wr_fire;
        end
    end

    assign map_valid      = map_valid_q;
    assign active_slot    = cur_slot;
    assign active_subslot = cur_sub;
    assign sslot_hit      = hit && cpu_rd;
    // Non-expanded page-3 slots never expose register contents.
    assign sslot_dout     = p3_expanded ? ~sslot_q[p3slot] : 8'h00;
    assign sslot_changed  = changed_q;

endmodule

// File: tb/tb_msx_slot_expander.sv
// tb_msx_slot_expander
//   Directed scenarios followed by random bus traffic. A behavioural model of
//   the slot map and subslot registers is compared against every DUT output
//   on every falling clock edge; a few literal expectations pin the model.
module tb_msx_slot_expander;

    localparam logic [3:0] MASK = 4'b1000;

    logic        clk21m = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq, cpu_rd, cpu_wr;
    logic [7:0]  ppi_out_a;
    logic        ppi_wr;
    logic        map_valid, sslot_hit, sslot_changed;
    logic [1:0]  active_slot, active_subslot;
    logic [7:0]  sslot_dout;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    msx_slot_expander #(
        .EXPANDED_MASK (MASK),
        .SSLOT_ADDR    (16'hFFFF),
        .RESET_SSLOT   (8'h00)
    ) dut (
        .clk21m         (clk21m),
        .reset_n        (reset_n),
        .cpu_addr       (cpu_addr),
        .cpu_dout       (cpu_dout),
        .cpu_mreq       (cpu_mreq),
        .cpu_rd         (cpu_rd),
        .cpu_wr         (cpu_wr),
        .ppi_out_a      (ppi_out_a),
        .ppi_wr         (ppi_wr),
        .map_valid      (map_valid),
        .active_slot    (active_slot),
        .active_subslot (active_subslot),
        .sslot_hit      (sslot_hit),
        .sslot_dout     (sslot_dout),
        .sslot_changed  (sslot_changed)
    );

    // ---------------- clock ----------------
    always #5 clk21m = ~clk21m;

    // ---------------- behavioural model ----------------
    // The model thinks in bus cycles: each bus cycle (cpu_mreq high span)
    // may deliver at most one subslot write.
    logic [7:0] m_sslot [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    bit         m_mapped      = 0;
    bit         m_bus_wrote   = 0;
    bit         m_changed     = 0;

    function automatic int p3_of();
        return m_mapped ? int'(ppi_out_a) / 64 : 0;
    endfunction

    function automatic bit reg_hit();
        return cpu_mreq && cpu_addr == 16'hFFFF && MASK[p3_of()];
    endfunction

    always @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_sslot[i] = 8'h00;
            m_mapped    = 0;
            m_bus_wrote = 0;
            m_changed   = 0;
        end else begin
            int  p3;
            bit  take;
            p3   = p3_of();
            take = reg_hit() && cpu_wr && !m_bus_wrote;
            m_changed = take;
            if (take) begin
                m_sslot[p3] = cpu_dout;
                m_bus_wrote = 1;
            end
            if (!cpu_mreq) m_bus_wrote = 0;
            if (ppi_wr) m_mapped = 1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk21m) begin
        int page, slot, sub, p3;
        page = int'(cpu_addr) / 16384;
        slot = m_mapped ? (int'(ppi_out_a) >> (2 * page)) % 4 : 0;
        sub  = MASK[slot] ? (int'(m_sslot[slot]) >> (2 * page)) % 4 : 0;
        p3   = p3_of();
        chk("map_valid",      {7'd0, map_valid},      {7'd0, m_mapped});
        chk("active_slot",    {6'd0, active_slot},    8'(slot));
        chk("active_subslot", {6'd0, active_subslot}, 8'(sub));
        chk("sslot_hit",      {7'd0, sslot_hit},      {7'd0, reg_hit() && cpu_rd});
        if (MASK[p3]) chk("sslot_dout", sslot_dout, ~m_sslot[p3]);
        chk("sslot_changed",  {7'd0, sslot_changed},  {7'd0, m_changed});
        if (sslot_changed) n_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk21m);
            #1;
        end
    endtask

    task automatic bus_idle();
        cpu_mreq = 0; cpu_rd = 0; cpu_wr = 0; ppi_wr = 0;
    endtask

    task automatic map_ppi(input logic [7:0] v);
        ppi_out_a = v; ppi_wr = 1;
        tick();
        ppi_wr = 0;
    endtask

    task automatic sslot_write(input logic [7:0] d, input int cycles);
        cpu_addr = 16'hFFFF; cpu_dout = d; cpu_mreq = 1; cpu_wr = 1; cpu_rd = 0;
        tick(cycles);
        bus_idle();
        tick();
    endtask

    task automatic probe(input logic [15:0] a);
        cpu_addr = a; cpu_mreq = 1; cpu_rd = 1; cpu_wr = 0;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 0; cpu_addr = 16'h0000; cpu_dout = 8'h00; ppi_out_a = 8'h00;
        bus_idle();
        tick(2);
        reset_n = 1;
        tick();

        // Unmapped after reset.
        probe(16'h4000);
        chk("rst_map_valid", {7'd0, map_valid}, 8'h00);
        chk("rst_slot",      {6'd0, active_slot}, 8'h00);
        chk("rst_sub",       {6'd0, active_subslot}, 8'h00);
        bus_idle();
        tick();

        // Map slot 3 into page 3, then a write stretched over 4 clocks.
        map_ppi(8'hC0);
        n_pulses = 0;
        cpu_addr = 16'hFFFF; cpu_dout = 8'h24; cpu_mreq = 1; cpu_wr = 1; cpu_rd = 0;
        tick();
        chk("chg_first", {7'd0, sslot_changed}, 8'h01);
        tick();
        chk("chg_second", {7'd0, sslot_changed}, 8'h00);
        tick(2);
        bus_idle();
        tick();
        chk("pulses_long_write", 8'(n_pulses), 8'h01);
        chk("model_sslot3", m_sslot[3], 8'h24);

        probe(16'h4000);
        chk("p1_slot_c0", {6'd0, active_slot}, 8'h00);
        chk("p1_sub_c0",  {6'd0, active_subslot}, 8'h00);
        ppi_out_a = 8'hFF;
        probe(16'h4000);
        chk("p1_slot_ff", {6'd0, active_slot}, 8'h03);
        chk("p1_sub_ff",  {6'd0, active_subslot}, 8'h01);
        probe(16'h8000);
        chk("p2_slot_ff", {6'd0, active_slot}, 8'h03);
        chk("p2_sub_ff",  {6'd0, active_subslot}, 8'h02);
        probe(16'hFFFF);
        chk("rd_hit",  {7'd0, sslot_hit}, 8'h01);
        chk("rd_dout", sslot_dout, 8'hDB);
        tick();
        bus_idle();
        tick();

        // Page 3 mapped to non-expanded slot 1: FFFFh is plain memory.
        ppi_out_a = 8'h40;
        probe(16'hFFFF);
        chk("nx_hit", {7'd0, sslot_hit}, 8'h00);
        bus_idle();
        n_pulses = 0;
        sslot_write(8'h55, 2);
        chk("nx_pulses", 8'(n_pulses), 8'h00);
        ppi_out_a = 8'hC0;
        probe(16'hFFFF);
        chk("nx_unchanged", sslot_dout, 8'hDB);
        bus_idle();
        tick();

        // Data change mid-cycle ignored; next bus cycle writes again.
        n_pulses = 0;
        cpu_addr = 16'hFFFF; cpu_dout = 8'hAA; cpu_mreq = 1; cpu_wr = 1; cpu_rd = 0;
        tick();
        cpu_dout = 8'h11;
        tick(2);
        bus_idle();
        tick();
        probe(16'hFFFF);
        chk("lock_aa", sslot_dout, 8'h55);
        bus_idle();
        tick();
        sslot_write(8'h11, 2);
        probe(16'hFFFF);
        chk("second_11", sslot_dout, 8'hEE);
        bus_idle();
        tick();
        chk("two_pulses", 8'(n_pulses), 8'h02);

        // Asynchronous reset between edges in the middle of a write.
        cpu_addr = 16'hFFFF; cpu_dout = 8'h77; cpu_mreq = 1; cpu_wr = 1;
        tick();
        #2;
        reset_n = 0;
        #1;
        chk("async_map_valid", {7'd0, map_valid}, 8'h00);
        chk("async_changed",   {7'd0, sslot_changed}, 8'h00);
        #3;
        bus_idle();
        tick();
        reset_n = 1;
        tick();

        // Same-edge PPI write and FFFFh write: map was invalid before the
        // edge, so page 3 resolves to slot 0 and nothing is written.
        ppi_out_a = 8'hC0; ppi_wr = 1;
        cpu_addr = 16'hFFFF; cpu_dout = 8'h99; cpu_mreq = 1; cpu_wr = 1;
        tick();
        bus_idle();
        tick();
        probe(16'hFFFF);
        chk("post_reset_reg", sslot_dout, 8'hFF);
        bus_idle();
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            cpu_addr = (sel < 2) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) cpu_dout = 8'($urandom_range(0, 255));
            cpu_mreq = ($urandom_range(0, 3) != 0);
            cpu_rd   = $urandom_range(0, 1);
            cpu_wr   = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) ppi_out_a = 8'($urandom_range(0, 255));
            ppi_wr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset_n = 0;
                tick();
                reset_n = 1;
            end
            tick();
        end
        bus_idle();
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
